best_path_selector: RTL and testbench
=====================================

# best_path_selector

Pipelined best-path selector for the Viterbi decoder, and the parametrised successor of the 4-state fixed selector. Each valid cycle it takes one path-metric/survivor-path pair per trellis state and finds the state with the smallest metric through a registered binary compare tree. It emits that state's survivor path, together with its index and metric, after a fixed latency. Paths travel through the tree alongside their metrics, so the selected path always belongs to the same input beat as the winning metric. It sits between the add-compare-select array and the traceback/output stage.

## Interface
- NUM_STATES, 4, number of trellis states; power of two, 2..64
- METRIC_W, 4, path-metric width, unsigned
- PATH_W, 8, survivor-path width
- STABLE_CNT, 4, consecutive identical outputs required for `converged` (only used with BPS_CONVERGE_EN); 1..255
- Localparam LVL = log2(NUM_STATES)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  input beat qualifier
- flush  in  1  synchronous clear of pipeline and history; takes priority over valid_in
- metrics_in  in  NUM_STATES*METRIC_W  state s metric at bits [s*METRIC_W +: METRIC_W]
- paths_in  in  NUM_STATES*PATH_W  state s survivor path at bits [s*PATH_W +: PATH_W]
- out  out  PATH_W  selected survivor path
- best_state  out  LVL  index of the winning state
- best_metric  out  METRIC_W  winning metric
- out_valid  out  1  out/best_state/best_metric valid this cycle
- refresh  out  1  with out_valid: out equals the previous valid out
- converged  out  1  out unchanged for STABLE_CNT consecutive valid beats

## Operation
- Compare tree has LVL registered levels. Level k reduces NUM_STATES>>k candidates to NUM_STATES>>(k+1).
- Each candidate carries {metric, index, path}.
- Pair compare: the left (lower-index) candidate wins when left.metric <= right.metric, so ties resolve to the lowest state index.
- Comparison is unsigned, METRIC_W bits, with no normalisation inside the block.
- A valid bit shifts alongside each level. A level's data registers load only when its incoming valid is 1 and otherwise hold.
- Final-level outputs drive out, best_state and best_metric directly.
- History register prev_out and flag has_prev update on each out_valid beat.
- refresh = out_valid & has_prev & (out == prev_out), registered so it aligns with out_valid.
- The first valid beat after reset or flush gives refresh=0.
- When out_valid=0, refresh=0.
- flush clears all level valid bits, has_prev and the stable counter. Data registers keep their values. out_valid=0 the next cycle.

## Timing
- Latency: valid_in at edge t gives out_valid at edge t+LVL. Example: NUM_STATES=4 gives latency 2.
- Throughput: one beat per cycle, no backpressure, no bubbles required.
- Reset values: out=0, best_state=0, best_metric=0, out_valid=0, refresh=0, converged=0; all internal valids, prev_out, has_prev and the counter are 0.
- Reset asserted mid-stream drops all in-flight beats. The first output after release comes LVL cycles after the first post-reset valid_in.
- flush and valid_in in the same cycle: that beat is dropped.
- Beats entering before a flush never produce outputs.

## Configuration
- Macro: BPS_CONVERGE_EN.
- Defined:
  - An 8-bit saturating counter increments on each refresh=1 beat.
  - It resets to 0 on an out_valid beat with refresh=0, on flush, and on reset.
  - converged = (counter >= STABLE_CNT), registered, and holds between valid beats.
- Not defined: the counter is not built and converged is tied to 0.

## Test plan
- Reset with NUM_STATES=4 defaults: hold rst_n=0 with random inputs toggling -> all outputs 0. After release, valid_in with metrics {s0..s3}={5,2,7,3} and paths {0x11,0x22,0x33,0x44} -> two cycles later out_valid=1, out=0x22, best_state=1, best_metric=2, refresh=0.
- Tie-break: metrics {4,4,4,4} -> best_state=0 and out=paths[0]. Metrics {9,6,6,1} -> best_state=3.
- Back-to-back streaming: 10 consecutive valid beats, each with a different winning state -> 10 consecutive out_valid cycles, each out matching its own beat's winner with no cross-beat mixing. Repeat with NUM_STATES=8 and METRIC_W=6: latency 3.
- Refresh: three consecutive beats all selecting path 0xA5 -> refresh sequence 0,1,1. A fourth beat selecting 0x5A -> refresh 0. A gap in valid_in between equal beats still gives refresh=1.
- Flush and reset mid-operation: flush one cycle after a valid beat -> that beat never emits and the next output has refresh=0. Pulse rst_n low for one cycle with 2 beats in flight -> no out_valid until 2 cycles after the next valid_in.
- BPS_CONVERGE_EN with STABLE_CNT=4: identical path for 5 beats -> converged rises after the 5th beat (4th refresh). Next differing beat clears it. Without the macro, converged stays 0 throughout.

Source files
------------

// File: rtl/best_path_selector.sv
// Pipelined minimum-metric selector: a registered binary compare tree over {metric, index, path} candidates.
// Optional macro BPS_CONVERGE_EN builds the output-stability counter that drives `converged`.
module best_path_selector #(
  parameter int NUM_STATES = 4,
  parameter int METRIC_W   = 4,
  parameter int PATH_W     = 8,
  parameter int STABLE_CNT = 4,
  localparam int LVL       = $clog2(NUM_STATES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  input  logic                           flush,
  input  logic [NUM_STATES*METRIC_W-1:0] metrics_in,
  input  logic [NUM_STATES*PATH_W-1:0]   paths_in,
  output logic [PATH_W-1:0]              out,
  output logic [LVL-1:0]                 best_state,
  output logic [METRIC_W-1:0]            best_metric,
  output logic                           out_valid,
  output logic                           refresh,
  output logic                           converged
);

  // Level k of cand_* holds the candidates entering compare level k; level LVL is the winner.
  logic [METRIC_W-1:0] cand_metric [LVL+1][NUM_STATES];
  logic [LVL-1:0]      cand_idx    [LVL+1][NUM_STATES];
  logic [PATH_W-1:0]   cand_path   [LVL+1][NUM_STATES];
  logic [LVL:0]        cand_valid;

  logic [METRIC_W-1:0] metric_next [LVL][NUM_STATES/2];
  logic [LVL-1:0]      idx_next    [LVL][NUM_STATES/2];
  logic [PATH_W-1:0]   path_next   [LVL][NUM_STATES/2];
  logic [METRIC_W-1:0] metric_reg  [LVL][NUM_STATES/2];
  logic [LVL-1:0]      idx_reg     [LVL][NUM_STATES/2];
  logic [PATH_W-1:0]   path_reg    [LVL][NUM_STATES/2];
  logic [LVL-1:0]      valid_reg;

  logic [PATH_W-1:0]   prev_out_reg;
  logic                has_prev_reg;
  logic                refresh_reg;
  logic                same_path;

  assign cand_valid = {valid_reg, valid_in};

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_STATES; gi++) begin : g_leaf
      assign cand_metric[0][gi] = metrics_in[gi*METRIC_W +: METRIC_W];
      assign cand_path[0][gi]   = paths_in[gi*PATH_W +: PATH_W];
      assign cand_idx[0][gi]    = LVL'(gi);
    end

    for (gi = 0; gi < LVL; gi++) begin : g_level
      localparam int CNT = NUM_STATES >> (gi + 1);
      for (gj = 0; gj < CNT; gj++) begin : g_node
        logic take_left;
        // Ties go left so the lowest state index wins.
        assign take_left = cand_metric[gi][2*gj] <= cand_metric[gi][2*gj+1];
        assign metric_next[gi][gj] = take_left ? cand_metric[gi][2*gj] : cand_metric[gi][2*gj+1];
        assign idx_next[gi][gj]    = take_left ? cand_idx[gi][2*gj]    : cand_idx[gi][2*gj+1];
        assign path_next[gi][gj]   = take_left ? cand_path[gi][2*gj]   : cand_path[gi][2*gj+1];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            metric_reg[gi][gj] <= '0;
            idx_reg[gi][gj]    <= '0;
            path_reg[gi][gj]   <= '0;
          end else if (cand_valid[gi] && !flush) begin
            metric_reg[gi][gj] <= metric_next[gi][gj];
            idx_reg[gi][gj]    <= idx_next[gi][gj];
            path_reg[gi][gj]   <= path_next[gi][gj];
          end
        end

        assign cand_metric[gi+1][gj] = metric_reg[gi][gj];
        assign cand_idx[gi+1][gj]    = idx_reg[gi][gj];
        assign cand_path[gi+1][gj]   = path_reg[gi][gj];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= cand_valid[LVL-1:0];
    end
  end

  // Refresh is decided while the winner enters the last level, so it lands with out_valid.
  assign same_path = has_prev_reg && (path_next[LVL-1][0] == prev_out_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_out_reg <= '0;
      has_prev_reg <= 1'b0;
      refresh_reg  <= 1'b0;
    end else if (flush) begin
      has_prev_reg <= 1'b0;
      refresh_reg  <= 1'b0;
    end else begin
      refresh_reg <= cand_valid[LVL-1] && same_path;
      if (cand_valid[LVL-1]) begin
        prev_out_reg <= path_next[LVL-1][0];
        has_prev_reg <= 1'b1;
      end
    end
  end

`ifdef BPS_CONVERGE_EN
  logic [7:0] cnt_reg;
  logic [7:0] cnt_next;
  logic       converged_reg;

  always_comb begin
    cnt_next = 8'd0;
    if (same_path) begin
      cnt_next = (cnt_reg == 8'hFF) ? 8'hFF : cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= 8'd0;
      converged_reg <= 1'b0;
    end else if (flush) begin
      cnt_reg       <= 8'd0;
      converged_reg <= 1'b0;
    end else if (cand_valid[LVL-1]) begin
      cnt_reg       <= cnt_next;
      converged_reg <= (cnt_next >= 8'(STABLE_CNT));
    end
  end

  assign converged = converged_reg;
`else
  assign converged = 1'b0;
`endif

  assign out         = cand_path[LVL][0];
  assign best_state  = cand_idx[LVL][0];
  assign best_metric = cand_metric[LVL][0];
  assign out_valid   = valid_reg[LVL-1];
  assign refresh     = refresh_reg;

endmodule

// File: tb/tb_best_path_selector.sv
// Self-checking bench for best_path_selector: a 4-state and an 8-state instance share one stimulus stream
// and are compared every cycle against an argmin/latency/history reference model.
module tb_best_path_selector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid_in, flush;
  logic [15:0] m4;
  logic [31:0] p4;
  logic [47:0] m8;
  logic [63:0] p8;
  logic [7:0]  o4, o8;
  logic [1:0]  bs4;
  logic [2:0]  bs8;
  logic [3:0]  bm4;
  logic [5:0]  bm8;
  logic        ov4, rf4, cv4, ov8, rf8, cv8;

  best_path_selector #(.NUM_STATES(4), .METRIC_W(4), .PATH_W(8), .STABLE_CNT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
    .metrics_in(m4), .paths_in(p4), .out(o4), .best_state(bs4), .best_metric(bm4),
    .out_valid(ov4), .refresh(rf4), .converged(cv4)
  );

  best_path_selector #(.NUM_STATES(8), .METRIC_W(6), .PATH_W(8), .STABLE_CNT(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
    .metrics_in(m8), .paths_in(p8), .out(o8), .best_state(bs8), .best_metric(bm8),
    .out_valid(ov8), .refresh(rf8), .converged(cv8)
  );

  typedef struct { bit v; int path; int st; int met; } beat_t;
  typedef struct {
    logic [3:0][7:0] m;
    logic [3:0][7:0] p;
    int e_st;
    int e_met;
    int e_path;
  } vec_t;

  int    mv[8];
  int    pv[8];
  beat_t pipe[2][3];
  bit    hp[2], ov_e[2], rf_e[2], cv_e[2];
  int    prev[2], cnt[2], eo[2], es[2], em[2];
  int    total = 0;
  int    bad = 0;
  int    rq[$], cq[$], sq4[$], pq4[$], sq8[$], pq8[$];
  int    nov4 = 0;
  int    nov8 = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic beat_t best(int n, int mask);
    beat_t b;
    b.v = 1'b1; b.st = 0; b.met = mv[0] & mask; b.path = pv[0];
    for (int s = 1; s < n; s++) begin
      if ((mv[s] & mask) < b.met) begin
        b.st = s; b.met = mv[s] & mask; b.path = pv[s];
      end
    end
    return b;
  endfunction

  task automatic pack();
    for (int s = 0; s < 4; s++) begin
      m4[s*4 +: 4] = 4'(mv[s]);
      p4[s*8 +: 8] = 8'(pv[s]);
    end
    for (int s = 0; s < 8; s++) begin
      m8[s*6 +: 6] = 6'(mv[s]);
      p8[s*8 +: 8] = 8'(pv[s]);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int lvl  = (d == 0) ? 2 : 3;
      int n    = (d == 0) ? 4 : 8;
      int mask = (d == 0) ? 15 : 63;
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) pipe[d][k].v = 1'b0;
        hp[d] = 0; prev[d] = 0; cnt[d] = 0; ov_e[d] = 0; rf_e[d] = 0; cv_e[d] = 0;
        eo[d] = 0; es[d] = 0; em[d] = 0;
      end else if (flush) begin
        for (int k = 0; k < 3; k++) pipe[d][k].v = 1'b0;
        hp[d] = 0; cnt[d] = 0; ov_e[d] = 0; rf_e[d] = 0; cv_e[d] = 0;
      end else begin
        for (int k = lvl - 1; k > 0; k--) pipe[d][k] = pipe[d][k-1];
        pipe[d][0]   = best(n, mask);
        pipe[d][0].v = valid_in;
        ov_e[d] = pipe[d][lvl-1].v;
        rf_e[d] = 1'b0;
        if (ov_e[d]) begin
          rf_e[d] = hp[d] && (pipe[d][lvl-1].path == prev[d]);
          eo[d] = pipe[d][lvl-1].path; es[d] = pipe[d][lvl-1].st; em[d] = pipe[d][lvl-1].met;
          prev[d] = eo[d]; hp[d] = 1'b1;
          cnt[d] = rf_e[d] ? ((cnt[d] < 255) ? cnt[d] + 1 : 255) : 0;
`ifdef BPS_CONVERGE_EN
          cv_e[d] = (cnt[d] >= 4);
`endif
        end
      end
    end
  endtask

  task automatic cmp(int d, logic [31:0] ov, logic [31:0] rf, logic [31:0] cv,
                     logic [31:0] o, logic [31:0] bs, logic [31:0] bm);
    chk($sformatf("out_valid%0d", d), ov, 32'(ov_e[d]));
    chk($sformatf("refresh%0d", d), rf, 32'(rf_e[d]));
    chk($sformatf("converged%0d", d), cv, 32'(cv_e[d]));
    chk($sformatf("out%0d", d), o, eo[d]);
    chk($sformatf("best_state%0d", d), bs, es[d]);
    chk($sformatf("best_metric%0d", d), bm, em[d]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp(0, 32'(ov4), 32'(rf4), 32'(cv4), 32'(o4), 32'(bs4), 32'(bm4));
    cmp(1, 32'(ov8), 32'(rf8), 32'(cv8), 32'(o8), 32'(bs8), 32'(bm8));
    if (ov4) begin
      nov4++;
      rq.push_back(int'(rf4)); cq.push_back(int'(cv4));
      sq4.push_back(int'(bs4)); pq4.push_back(int'(o4));
      $display("beat n=4 state=%0d metric=%0d path=%02h refresh=%0b converged=%0b",
               bs4, bm4, o4, rf4, cv4);
    end
    if (ov8) begin
      nov8++;
      sq8.push_back(int'(bs8)); pq8.push_back(int'(o8));
    end
  endtask

  function automatic vec_t mk(int a0, int a1, int a2, int a3, int q0, int q1, int q2, int q3,
                              int st, int met, int path);
    vec_t v;
    v.m[0] = 8'(a0); v.m[1] = 8'(a1); v.m[2] = 8'(a2); v.m[3] = 8'(a3);
    v.p[0] = 8'(q0); v.p[1] = 8'(q1); v.p[2] = 8'(q2); v.p[3] = 8'(q3);
    v.e_st = st; v.e_met = met; v.e_path = path;
    return v;
  endfunction

  task automatic all_paths(int p);
    for (int s = 0; s < 8; s++) pv[s] = p;
  endtask

  task automatic rand_metrics();
    for (int s = 0; s < 8; s++) mv[s] = int'($urandom_range(0, 63));
  endtask

  initial begin
    vec_t tbl[5];
    int   seq[10];
    int   exp_rf[10];
    int   exp_cv[10];
    int   l4, l8;

    tbl[0] = mk(5, 2, 7, 3,    'h11, 'h22, 'h33, 'h44, 1, 2,  'h22);
    tbl[1] = mk(4, 4, 4, 4,    'h10, 'h20, 'h30, 'h40, 0, 4,  'h10);
    tbl[2] = mk(9, 6, 6, 1,    'h01, 'h02, 'h03, 'h04, 3, 1,  'h04);
    tbl[3] = mk(15, 15, 15, 14, 'hE1, 'hE2, 'hE3, 'hE4, 3, 14, 'hE4);
    tbl[4] = mk(0, 15, 0, 0,   'hC1, 'hC2, 'hC3, 'hC4, 0, 0,  'hC1);
    seq    = '{'hA5, 'hA5, 'hA5, 'h5A, 'h5A, 'h5A, 'h5A, 'h5A, 'h5A, 'h3C};
    exp_rf = '{0, 1, 1, 0, 1, 1, 1, 1, 1, 0};
`ifdef BPS_CONVERGE_EN
    exp_cv = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
`else
    exp_cv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    // Reset held with inputs toggling
    rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_metrics();
      for (int s = 0; s < 8; s++) pv[s] = int'($urandom_range(0, 255));
      valid_in = 1'($urandom_range(0, 1));
      pack();
      step();
    end
    chk("rst_out", 32'(o4), 0);
    chk("rst_state", 32'(bs4), 0);
    chk("rst_metric", 32'(bm4), 0);
    chk("rst_valid", 32'(ov4), 0);
    chk("rst_refresh", 32'(rf4), 0);
    chk("rst_converged", 32'(cv4), 0);
    rst_n = 1'b1; valid_in = 1'b0;
    step();

    // Table-driven single beats
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 4; s++) begin
        mv[s] = int'(tbl[i].m[s]);
        pv[s] = int'(tbl[i].p[s]);
      end
      for (int s = 4; s < 8; s++) begin
        mv[s] = 63; pv[s] = 'hFF;
      end
      valid_in = 1'b1; pack(); step();
      valid_in = 1'b0; step();
      chk("tbl_valid4", 32'(ov4), 1);
      chk("tbl_state4", 32'(bs4), tbl[i].e_st);
      chk("tbl_metric4", 32'(bm4), tbl[i].e_met);
      chk("tbl_path4", 32'(o4), tbl[i].e_path);
      if (i == 0) chk("tbl_first_refresh", 32'(rf4), 0);
      step();
      chk("tbl_valid8", 32'(ov8), 1);
      chk("tbl_state8", 32'(bs8), tbl[i].e_st);
      chk("tbl_metric8", 32'(bm8), tbl[i].e_met);
      chk("tbl_path8", 32'(o8), tbl[i].e_path);
    end

    // Back-to-back streaming, winner moves every beat
    sq4.delete(); pq4.delete(); sq8.delete(); pq8.delete();
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 8; s++) begin
        mv[s] = 20 + int'($urandom_range(0, 9));
        pv[s] = i * 16 + s;
      end
      mv[i % 4] = 1;
      mv[i % 8] = 0;
      valid_in = 1'b1; pack(); step();
    end
    valid_in = 1'b0;
    repeat (4) step();
    chk("stream_count4", sq4.size(), 10);
    chk("stream_count8", sq8.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < sq4.size()) begin
        chk("stream_state4", sq4[i], i % 4);
        chk("stream_path4", pq4[i], i * 16 + i % 4);
      end
      if (i < sq8.size()) begin
        chk("stream_state8", sq8[i], i % 8);
        chk("stream_path8", pq8[i], i * 16 + i % 8);
      end
    end

    // Refresh and convergence sequence, with one gap
    rq.delete(); cq.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        valid_in = 1'b0;
        repeat (3) step();
      end
      rand_metrics(); all_paths(seq[i]);
      valid_in = 1'b1; pack(); step();
    end
    valid_in = 1'b0;
    repeat (4) step();
    chk("refresh_count", rq.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < rq.size()) begin
        chk($sformatf("refresh_seq%0d", i), rq[i], exp_rf[i]);
        chk($sformatf("converged_seq%0d", i), cq[i], exp_cv[i]);
      end
    end

    // Flush one cycle after a beat, then flush colliding with valid_in
    nov4 = 0; rq.delete(); pq4.delete();
    rand_metrics(); all_paths('h77);
    valid_in = 1'b1; pack(); step();
    valid_in = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    repeat (4) step();
    chk("flush_drop", nov4, 0);
    all_paths('h3C);
    valid_in = 1'b1; pack(); step();
    valid_in = 1'b0;
    repeat (3) step();
    chk("flush_next_count", nov4, 1);
    if (rq.size() > 0) begin
      chk("flush_next_refresh", rq[0], 0);
      chk("flush_next_path", pq4[0], 'h3C);
    end
    valid_in = 1'b1; flush = 1'b1; pack(); step();
    valid_in = 1'b0; flush = 1'b0;
    repeat (4) step();
    chk("flush_same_cycle", nov4, 1);

    // Reset pulse with beats in flight
    rand_metrics(); all_paths('h99);
    valid_in = 1'b1; pack(); step();
    all_paths('h9A); pack(); step();
    valid_in = 1'b0; rst_n = 1'b0; step();
    rst_n = 1'b1; nov4 = 0; nov8 = 0;
    repeat (4) step();
    chk("rst_drop4", nov4, 0);
    chk("rst_drop8", nov8, 0);
    l4 = 0; l8 = 0;
    rand_metrics(); all_paths('h42);
    valid_in = 1'b1; pack();
    for (int c = 1; c <= 10; c++) begin
      step();
      valid_in = 1'b0;
      if (ov4 && l4 == 0) l4 = c;
      if (ov8 && l8 == 0) l8 = c;
    end
    chk("latency4", l4, 2);
    chk("latency8", l8, 3);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      valid_in = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      rand_metrics();
      if ($urandom_range(0, 1) == 1) begin
        all_paths(($urandom_range(0, 1) == 1) ? 'hA5 : 'h5A);
      end else begin
        for (int s = 0; s < 8; s++) pv[s] = int'($urandom_range(0, 255));
      end
      pack();
      step();
    end
    rst_n = 1'b1; valid_in = 1'b0; flush = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
